// File: rtl/comp_share_arb_pkg.sv
// Shared definitions for the comparator-sharing arbiter.
// Holds the control FSM state encoding and the default operand width
// used by the FP datapath comparator.
package comp_share_arb_pkg;

  // Default operand width; the shared comparator is built for this width.
  localparam int SIZE_DATA_DEFAULT = 28;

  // Control FSM: accept a request, run the compare, hold the response.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RSP  = 2'd2
  } state_e;

endpackage : comp_share_arb_pkg

// File: rtl/comp_share_arb_lt_cmp.sv
// Unsigned less-than comparator used as the shared resource.
// Ports:
//   a_i  : operand A (W bits, unsigned)
//   b_i  : operand B (W bits, unsigned)
//   lt_o : 1 when a_i < b_i
module lt_cmp #(
  parameter int W = 28
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o
);

  assign lt_o = (a_i < b_i);

endmodule : lt_cmp

// File: rtl/comp_share_arb_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above the
// pointer, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req_i     : request vector
//   ptr_i     : highest-priority requester index for this arbitration
//   en_i      : arbitration enable; grant is all-zero when low
//   gnt_o     : one-hot grant
//   gnt_idx_o : index of the granted requester (0 when nothing granted)
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  int   k_s;
  logic found_s;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    k_s       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k_s = (int'(ptr_i) + off) % NUM_REQ;
      if (en_i && !found_s && req_i[k_s]) begin
        gnt_o[k_s] = 1'b1;
        gnt_idx_o  = ID_W'(k_s);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/comp_share_arb.sv
// Time-shares one unsigned less-than comparator between NUM_REQ requesters.
// A request is granted round-robin in S_IDLE, its operands are registered,
// compared in S_CMP, and the result is held in S_RSP until consumed.
// Ports:
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_req_valid     : per-requester valid
//   i_req_data_a/b  : packed operands, requester k at [k*SIZE_DATA +: SIZE_DATA]
//   o_req_ready     : one-hot grant (combinational, only in S_IDLE)
//   o_rsp_valid     : response valid, held until i_rsp_ready
//   o_rsp_id        : requester that owns the response
//   o_rsp_less      : A < B (unsigned)
//   o_rsp_equal     : A == B
//   i_rsp_ready     : consumer accepts the response
module comp_share_arb
  import comp_share_arb_pkg::*;
#(
  parameter int SIZE_DATA = SIZE_DATA_DEFAULT,
  parameter int NUM_REQ   = 2,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data_b,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_rsp_valid,
  output logic [ID_W-1:0]              o_rsp_id,
  output logic                         o_rsp_less,
  output logic                         o_rsp_equal,
  input  logic                         i_rsp_ready
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [SIZE_DATA-1:0] op_a_q, op_a_d;
  logic [SIZE_DATA-1:0] op_b_q, op_b_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_less_q, rsp_less_d;
  logic                 rsp_equal_q, rsp_equal_d;

  logic [NUM_REQ-1:0]   gnt_s;
  logic [ID_W-1:0]      gnt_idx_s;
  logic                 less_s;
  logic                 equal_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i     (i_req_valid),
    .ptr_i     (ptr_q),
    .en_i      (state_q == S_IDLE),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s)
  );

  // The shared comparator only ever sees the registered operands.
  lt_cmp #(
    .W (SIZE_DATA)
  ) u_lt_cmp (
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .lt_o (less_s)
  );

  assign equal_s     = (op_a_q == op_b_q);
  assign o_req_ready = gnt_s;

  // Next-state, operand capture and response update.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_less_d  = rsp_less_q;
    rsp_equal_d = rsp_equal_q;
    case (state_q)
      S_IDLE: begin
        // The grant is only non-zero on a valid bit, so any grant is an accept.
        if (|gnt_s) begin
          op_a_d  = i_req_data_a[gnt_idx_s*SIZE_DATA +: SIZE_DATA];
          op_b_d  = i_req_data_b[gnt_idx_s*SIZE_DATA +: SIZE_DATA];
          id_d    = gnt_idx_s;
          ptr_d   = (gnt_idx_s == ID_W'(NUM_REQ-1)) ? '0 : (gnt_idx_s + ID_W'(1));
          state_d = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_less_d  = less_s;
        rsp_equal_d = equal_s;
        state_d     = S_RSP;
      end
      S_RSP: begin
        // Id/less/equal stay as they are after the handshake.
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_RSP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_less_q  <= 1'b0;
      rsp_equal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_less_q  <= rsp_less_d;
      rsp_equal_q <= rsp_equal_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_less  = rsp_less_q;
  assign o_rsp_equal = rsp_equal_q;

endmodule : comp_share_arb

// File: tb/tb_comp_share_arb.sv
// Directed self-checking bench for comp_share_arb (NUM_REQ = 2).
module tb_comp_share_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [55:0] data_a;
  logic [55:0] data_b;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic        rsp_less;
  logic        rsp_equal;
  logic        rsp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  comp_share_arb #(
    .SIZE_DATA (28),
    .NUM_REQ   (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data_a (data_a),
    .i_req_data_b (data_b),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_less   (rsp_less),
    .o_rsp_equal  (rsp_equal),
    .i_rsp_ready  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // One full transaction with an always-ready consumer.
  task automatic txn(input string tag, input logic [1:0] v,
                     input logic [27:0] a0, input logic [27:0] b0,
                     input logic [27:0] a1, input logic [27:0] b1,
                     input logic [1:0] exp_gnt, input logic exp_id,
                     input logic exp_less, input logic exp_eq, input logic keep);
    req_valid = v;
    data_a    = {a1, a0};
    data_b    = {b1, b0};
    rsp_ready = 1'b1;
    #1;
    check({tag, "_gnt"}, 32'(req_ready), 32'(exp_gnt));
    step;
    if (!keep) req_valid = 2'b00;
    #1;
    check({tag, "_cmp_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_cmp_valid"}, 32'(rsp_valid), 32'd0);
    step;
    #1;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_id"},    32'(rsp_id),    32'(exp_id));
    check({tag, "_rsp_less"},  32'(rsp_less),  32'(exp_less));
    check({tag, "_rsp_equal"}, 32'(rsp_equal), 32'(exp_eq));
    check({tag, "_rsp_ready"}, 32'(req_ready), 32'd0);
    step;
    #1;
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    data_a    = 56'd0;
    data_b    = 56'd0;
    rsp_ready = 1'b1;

    // Reset held for two edges with nothing requesting.
    step;
    step;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_less",  32'(rsp_less),  32'd0);
    check("rst_equal", 32'(rsp_equal), 32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    rst_n = 1'b1;

    // Basic compares; pointer goes 0 -> 1 -> 0 -> 0 -> 0.
    txn("single", 2'b01, 28'h0000010, 28'h0000020, 28'h0, 28'h0,
        2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    txn("equal", 2'b10, 28'h0, 28'h0, 28'hABCDEF1, 28'hABCDEF1,
        2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    txn("greater", 2'b10, 28'h0, 28'h0, 28'hFFFFFFF, 28'h0FFFFFF,
        2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    txn("extremes", 2'b10, 28'h0, 28'h0, 28'h0000000, 28'hFFFFFFF,
        2'b10, 1'b1, 1'b1, 1'b0, 1'b0);

    // Both requesters continuously valid: grants alternate starting at 0.
    for (int i = 0; i < 4; i++) begin
      txn($sformatf("fair%0d", i), 2'b11, 28'd5, 28'd3, 28'd3, 28'd5,
          (i % 2 == 0) ? 2'b01 : 2'b10, 1'(i % 2), 1'(i % 2), 1'b0, 1'b1);
    end

    // Backpressure: response held while the consumer stalls.
    req_valid = 2'b11;
    data_a    = {28'd9, 28'd7};
    data_b    = {28'd7, 28'd9};
    rsp_ready = 1'b0;
    #1;
    check("bp_gnt", 32'(req_ready), 32'b01);
    step;
    #1;
    check("bp_cmp_ready", 32'(req_ready), 32'd0);
    step;
    #1;
    check("bp_valid", 32'(rsp_valid), 32'd1);
    check("bp_less",  32'(rsp_less),  32'd1);
    for (int i = 0; i < 5; i++) begin
      step;
      #1;
      check($sformatf("bp_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_hold_id%0d", i),    32'(rsp_id),    32'd0);
      check($sformatf("bp_hold_less%0d", i),  32'(rsp_less),  32'd1);
      check($sformatf("bp_hold_eq%0d", i),    32'(rsp_equal), 32'd0);
      check($sformatf("bp_hold_ready%0d", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step;
    #1;
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_less",  32'(rsp_less),  32'd1);
    check("bp_next_gnt",      32'(req_ready), 32'b10);
    req_valid = 2'b00;
    #1;
    check("bp_drop_ready", 32'(req_ready), 32'd0);
    step;
    #1;
    check("bp_idle_ready", 32'(req_ready), 32'd0);
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);

    // Reset during S_CMP: compare discarded, pointer back to 0.
    req_valid = 2'b01;
    data_a    = {28'd0, 28'd1};
    data_b    = {28'd0, 28'd2};
    #1;
    check("rmid_gnt", 32'(req_ready), 32'b01);
    step;
    req_valid = 2'b00;
    rst_n     = 1'b0;
    step;
    rst_n = 1'b1;
    #1;
    check("rmid_valid0", 32'(rsp_valid), 32'd0);
    check("rmid_ready0", 32'(req_ready), 32'd0);
    check("rmid_less0",  32'(rsp_less),  32'd0);
    step;
    #1;
    check("rmid_valid1", 32'(rsp_valid), 32'd0);
    txn("rmid_rr", 2'b11, 28'd3, 28'd3, 28'd4, 28'd1,
        2'b01, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_comp_share_arb
